// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: drives the next-PC mux select and sequential
// candidate, registers the mux result, and owns run/stall/halt state.
module fetch_pc_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [W-1:0]     StartAddr,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic             Jump,
    input  logic             HaltReq,
    input  logic [W-1:0]     PCNext,
    output logic [1:0]       PCSel,
    output logic [W-1:0]     PCPlus1,
    output logic [W-1:0]     PC,
    output logic             InstValid,
    output logic             Halted,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_JMP = 2'b10;

    state_t state;
    logic   run;
    logic   adv;
    logic   cnt_sat;

    assign run     = (state == S_RUN);
    assign adv     = run && !HaltReq && !Stall;
    assign cnt_sat = &CycleCount;

    assign PCPlus1 = PC + W'(1);

    // Jump outranks a simultaneous taken branch.
    always_comb begin
        PCSel = SEL_SEQ;
        if (adv) begin
            unique case (1'b1)
                Jump:                 PCSel = SEL_JMP;
                !Jump && BranchTaken: PCSel = SEL_BR;
                default:              PCSel = SEL_SEQ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            PC         <= '0;
            InstValid  <= 1'b0;
            Halted     <= 1'b0;
            CycleCount <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_HALTED: begin
                    if (Start) begin
                        state      <= S_RUN;
                        PC         <= StartAddr;
                        InstValid  <= 1'b1;
                        Halted     <= 1'b0;
                        CycleCount <= '0;
                    end
                end
                S_RUN: begin
                    if (!cnt_sat)
                        CycleCount <= CycleCount + CNT_W'(1);
                    if (HaltReq) begin
                        state     <= S_HALTED;
                        InstValid <= 1'b0;
                        Halted    <= 1'b1;
                    end else if (!Stall) begin
                        PC <= PCNext;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    InstValid <= 1'b0;
                    Halted    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: directed vectors push expected
// outputs; a monitor pops and compares once per cycle.
module tb_fetch_pc_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [7:0]  StartAddr;
    logic        Stall;
    logic        BranchTaken;
    logic        Jump;
    logic        HaltReq;
    logic [7:0]  PCNext;
    logic [1:0]  PCSel;
    logic [7:0]  PCPlus1;
    logic [7:0]  PC;
    logic        InstValid;
    logic        Halted;
    logic [15:0] CycleCount;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [1:0]  sel;
        logic        iv;
        logic        h;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    fetch_pc_ctrl #(.W(8), .CNT_W(16)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .Start(Start),
        .StartAddr(StartAddr),
        .Stall(Stall),
        .BranchTaken(BranchTaken),
        .Jump(Jump),
        .HaltReq(HaltReq),
        .PCNext(PCNext),
        .PCSel(PCSel),
        .PCPlus1(PCPlus1),
        .PC(PC),
        .InstValid(InstValid),
        .Halted(Halted),
        .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Monitor: DUT outputs settle after the inputs change on the falling edge.
    always @(negedge Clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc", 16'(PC), 16'(e.pc));
            check("pcsel", 16'(PCSel), 16'(e.sel));
            check("pcplus1", 16'(PCPlus1), 16'(8'(e.pc + 8'd1)));
            check("instvalid", 16'(InstValid), 16'(e.iv));
            check("halted", 16'(Halted), 16'(e.h));
            check("cyclecount", CycleCount, e.cnt);
        end
    end

    // Drive one cycle of inputs and record the outputs expected before
    // the following rising edge.
    task automatic step(input logic rst, input logic st, input logic [7:0] sa,
                        input logic stl, input logic br, input logic jp,
                        input logic hr, input logic [7:0] nx,
                        input logic [7:0] epc, input logic [1:0] esel,
                        input logic eiv, input logic eh,
                        input logic [15:0] ecnt);
        exp_t e;
        @(negedge Clk);
        Reset_n     = rst;
        Start       = st;
        StartAddr   = sa;
        Stall       = stl;
        BranchTaken = br;
        Jump        = jp;
        HaltReq     = hr;
        PCNext      = nx;
        e.pc  = epc;
        e.sel = esel;
        e.iv  = eiv;
        e.h   = eh;
        e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    initial begin
        Reset_n     = 1'b0;
        Start       = 1'b0;
        StartAddr   = 8'h00;
        Stall       = 1'b0;
        BranchTaken = 1'b0;
        Jump        = 1'b0;
        HaltReq     = 1'b0;
        PCNext      = 8'h00;

        //   rst st  sa    stl br jp hr nx     pc     sel   iv h  cnt
        step(0, 1, 8'h99, 0, 0, 1, 0, 8'h00, 8'h00, 2'b00, 0, 0, 16'd0);
        // sequential run from 10
        step(1, 1, 8'h10, 0, 0, 0, 0, 8'h00, 8'h00, 2'b00, 0, 0, 16'd0);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h11, 8'h10, 2'b00, 1, 0, 16'd0);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h12, 8'h11, 2'b00, 1, 0, 16'd1);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h13, 8'h12, 2'b00, 1, 0, 16'd2);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h14, 8'h13, 2'b00, 1, 0, 16'd3);
        step(1, 0, 8'h00, 0, 0, 1, 0, 8'h20, 8'h14, 2'b10, 1, 0, 16'd4);
        // branch, then jump+branch from 20
        step(1, 0, 8'h00, 0, 1, 0, 0, 8'h05, 8'h20, 2'b01, 1, 0, 16'd5);
        step(1, 0, 8'h00, 0, 0, 1, 0, 8'h20, 8'h05, 2'b10, 1, 0, 16'd6);
        step(1, 0, 8'h00, 0, 1, 1, 0, 8'h40, 8'h20, 2'b10, 1, 0, 16'd7);
        step(1, 0, 8'h00, 0, 0, 1, 0, 8'h30, 8'h40, 2'b10, 1, 0, 16'd8);
        // stall with jump pending at 30
        step(1, 0, 8'h00, 1, 0, 1, 0, 8'h77, 8'h30, 2'b00, 1, 0, 16'd9);
        step(1, 0, 8'h00, 1, 0, 1, 0, 8'h77, 8'h30, 2'b00, 1, 0, 16'd10);
        step(1, 0, 8'h00, 1, 0, 1, 0, 8'h77, 8'h30, 2'b00, 1, 0, 16'd11);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h31, 8'h30, 2'b00, 1, 0, 16'd12);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h32, 8'h31, 2'b00, 1, 0, 16'd13);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h33, 8'h32, 2'b00, 1, 0, 16'd14);
        // halt together with stall at 33
        step(1, 0, 8'h00, 1, 0, 0, 1, 8'h55, 8'h33, 2'b00, 1, 0, 16'd15);
        step(1, 0, 8'h00, 0, 1, 1, 0, 8'h66, 8'h33, 2'b00, 0, 1, 16'd16);
        step(1, 1, 8'h00, 0, 0, 0, 0, 8'h66, 8'h33, 2'b00, 0, 1, 16'd16);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h01, 8'h00, 2'b00, 1, 0, 16'd0);
        // Start while running is ignored
        step(1, 1, 8'hFE, 0, 0, 0, 0, 8'h02, 8'h01, 2'b00, 1, 0, 16'd1);
        step(1, 0, 8'h00, 0, 0, 0, 1, 8'h88, 8'h02, 2'b00, 1, 0, 16'd2);
        // wrap through FF
        step(1, 1, 8'hFE, 0, 0, 0, 0, 8'h88, 8'h02, 2'b00, 0, 1, 16'd3);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 8'hFE, 2'b00, 1, 0, 16'd0);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF, 2'b00, 1, 0, 16'd1);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h01, 8'h00, 2'b00, 1, 0, 16'd2);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h02, 8'h01, 2'b00, 1, 0, 16'd3);
        // async reset mid-run, then Start with HaltReq in IDLE
        step(0, 0, 8'h00, 0, 0, 1, 0, 8'h09, 8'h00, 2'b00, 0, 0, 16'd0);
        step(1, 1, 8'h50, 0, 0, 0, 1, 8'h09, 8'h00, 2'b00, 0, 0, 16'd0);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h51, 8'h50, 2'b00, 1, 0, 16'd0);
        step(1, 0, 8'h00, 0, 0, 0, 0, 8'h52, 8'h51, 2'b00, 1, 0, 16'd1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, need 0",
                     exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
